// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 chain driver: FSM state encoding and frame timing.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SH_LO = 2'd1,
    SH_HI = 2'd2,
    LATCH = 2'd3
  } state_e;

  // Clk cycles from the first SH_LO cycle to the last LATCH cycle.
  function automatic int frame_cycles(input int data_w, input int div);
    return 2 * div * data_w + div;
  endfunction

endpackage

// File: rtl/hc595_phase_tick.sv
// Phase divider: tick_o is high in the last cycle of every DIV-cycle window.
// clr_i restarts the window so each FSM state gets exactly DIV cycles.
module hc595_phase_tick #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hc595_chain_driver.sv
// Serial engine for a 74HC595 daisy chain with start/busy/done handshake,
// a one-deep pending frame and optional continuous refresh. All pins registered.
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DIV          = 2,
  parameter bit LSB_FIRST    = 1'b0,
  parameter bit AUTO_REFRESH = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sh_cp_o,
  output logic              st_cp_o,
  output logic              ds_o
);

  localparam int BW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              pend_q, pend_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sh_cp_q, sh_cp_d, st_cp_q, st_cp_d, ds_q, ds_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              tick, reload;

  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_W-1];
  endfunction

  hc595_phase_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (state_d != state_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = start_i ? data_i : hold_q;
    sh_d    = sh_q;
    pend_d  = pend_q | (start_i && (state_q != IDLE));
    bit_d   = bit_q;
    done_d  = 1'b0;
    reload  = 1'b0;

    case (state_q)
      IDLE:  if (start_i || pend_q || AUTO_REFRESH) reload = 1'b1;
      SH_LO: if (tick) state_d = SH_HI;
      SH_HI: if (tick) begin
        sh_d = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
        if (bit_q == BW'(DATA_W - 1)) begin
          state_d = LATCH;
        end else begin
          bit_d   = bit_q + BW'(1);
          state_d = SH_LO;
        end
      end
      LATCH: if (tick) begin
        done_d = 1'b1;
        if (start_i || pend_q || AUTO_REFRESH) reload = 1'b1;
        else                                   state_d = IDLE;
      end
    endcase

    // A Start in the reload cycle wins over the held frame and clears pend.
    if (reload) begin
      state_d = SH_LO;
      sh_d    = start_i ? data_i : hold_q;
      pend_d  = 1'b0;
      bit_d   = '0;
    end

    // Pins follow the next state so they change together with the state register.
    sh_cp_d = (state_d == SH_HI);
    st_cp_d = (state_d == LATCH);
    busy_d  = (state_d != IDLE);
    ds_d    = (state_d == SH_LO) ? out_bit(sh_d) : ds_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sh_q    <= '0;
      pend_q  <= 1'b0;
      bit_q   <= '0;
      sh_cp_q <= 1'b0;
      st_cp_q <= 1'b0;
      ds_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      bit_q   <= bit_d;
      sh_cp_q <= sh_cp_d;
      st_cp_q <= st_cp_d;
      ds_q    <= ds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sh_cp_o = sh_cp_q;
  assign st_cp_o = st_cp_q;
  assign ds_o    = ds_q;

endmodule
